// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Purpose  : start/done request and result bundle for serial_subtractor.
//             V and its modport entries exist only with SERIAL_SUB_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             V;

    modport master (
        output start, A, B, Bi,
        input  busy, done, D, Bo, V
    );

    modport slave (
        input  start, A, B, Bi,
        output busy, done, D, Bo, V
    );
`else
    modport master (
        output start, A, B, Bi,
        input  busy, done, D, Bo
    );

    modport slave (
        input  start, A, B, Bi,
        output busy, done, D, Bo
    );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : bit-serial A - B - Bi, LSB first, one bit per clock with a
//             single borrow flip-flop. Optional V output: SERIAL_SUB_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_subtractor_if.slave sub_bus
);
    localparam int               c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [c_CW-1:0]  r_cnt;
    logic             r_br;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_v;
`endif

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    always_comb begin
        w_a        = r_a_sh[0];
        w_b        = r_b_sh[0];
        w_d        = w_a ^ w_b ^ r_br;
        w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
        w_res_next = {w_d, r_res[WIDTH-1:1]};
        w_accept   = sub_bus.start && ((r_state == c_IDLE) || (r_state == c_DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_v     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_a_sh  <= sub_bus.A;
                        r_b_sh  <= sub_bus.B;
                        r_br    <= sub_bus.Bi;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res  <= w_res_next;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        // On the last bit w_a/w_b are the operand MSBs and w_d is D's MSB.
                        r_d     <= w_res_next;
                        r_bo    <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        r_v     <= (w_a ^ w_b) & (w_d ^ w_a);
`endif
                        r_state <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign sub_bus.busy = (r_state == c_RUN);
    assign sub_bus.done = (r_state == c_DONE);
    assign sub_bus.D    = r_d;
    assign sub_bus.Bo   = r_bo;
`ifdef SERIAL_SUB_OVF_EN
    assign sub_bus.V    = r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : directed and exhaustive checks of serial_subtractor, WIDTH=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int c_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    int   busy_cnt;
    int   cyc;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(c_W)) sub_bus ();

    serial_subtractor #(.WIDTH(c_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sub_bus (sub_bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic bi);
        sub_bus.A     = a;
        sub_bus.B     = b;
        sub_bus.Bi    = bi;
        sub_bus.start = 1'b1;
        step();
        sub_bus.start = 1'b0;
    endtask

    // Counts edges after the accept edge until done, with a bounded budget.
    task automatic wait_done(output int n);
        n        = 0;
        busy_cnt = 0;
        while (!sub_bus.done && n < 20) begin
            if (sub_bus.busy) busy_cnt++;
            step();
            n++;
        end
    endtask

    task automatic run_check(input logic [3:0] a, input logic [3:0] b, input logic bi);
        logic [4:0] ref_diff;
        int         n;
        ref_diff = {1'b0, a} - {1'b0, b} - {4'b0, bi};
        start_op(a, b, bi);
        wait_done(n);
        chk("ex_lat", n, 4);
        chk("ex_D",   sub_bus.D,  ref_diff[3:0]);
        chk("ex_Bo",  sub_bus.Bo, ref_diff[4]);
`ifdef SERIAL_SUB_OVF_EN
        chk("ex_V", sub_bus.V, (a[3] ^ b[3]) & (ref_diff[3] ^ a[3]));
`endif
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        sub_bus.start = 1'b0;
        sub_bus.A     = '0;
        sub_bus.B     = '0;
        sub_bus.Bi    = 1'b0;
        step();
        step();
        chk("rst_busy", sub_bus.busy, 0);
        chk("rst_done", sub_bus.done, 0);
        chk("rst_D",    sub_bus.D,    0);
        chk("rst_Bo",   sub_bus.Bo,   0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_V",    sub_bus.V,    0);
`endif
        rst = 1'b0;
        step();

        // 1: basic latency and busy width
        start_op(4'd9, 4'd3, 1'b0);
        chk("t1_busy0", sub_bus.busy, 1);
        chk("t1_Dheld", sub_bus.D, 0);
        wait_done(cyc);
        chk("t1_lat",   cyc, 4);
        chk("t1_busyn", busy_cnt, 4);
        chk("t1_busy",  sub_bus.busy, 0);
        chk("t1_D",     sub_bus.D, 4'd6);
        chk("t1_Bo",    sub_bus.Bo, 0);
        step();
        chk("t1_pulse", sub_bus.done, 0);
        chk("t1_Dhold", sub_bus.D, 4'd6);

        // 2: borrow and wrap-around
        start_op(4'd3, 4'd9, 1'b0);
        wait_done(cyc);
        chk("t2a_D",  sub_bus.D, 4'hA);
        chk("t2a_Bo", sub_bus.Bo, 1);
        step();
        start_op(4'd0, 4'd0, 1'b1);
        wait_done(cyc);
        chk("t2b_D",  sub_bus.D, 4'hF);
        chk("t2b_Bo", sub_bus.Bo, 1);
        step();

        // 3: start during RUN is ignored
        start_op(4'd5, 4'd2, 1'b0);
        step();
        sub_bus.A     = 4'd0;
        sub_bus.B     = 4'd1;
        sub_bus.start = 1'b1;
        step();
        sub_bus.start = 1'b0;
        wait_done(cyc);
        chk("t3_lat", cyc, 2);
        chk("t3_D",   sub_bus.D, 4'd3);
        chk("t3_Bo",  sub_bus.Bo, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_nodone", {sub_bus.done, sub_bus.busy}, 0);
        end

        // 4: reset aborts an operation
        start_op(4'd8, 4'd1, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_busy", sub_bus.busy, 0);
        chk("t4_done", sub_bus.done, 0);
        chk("t4_D",    sub_bus.D, 0);
        chk("t4_Bo",   sub_bus.Bo, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_idle", {sub_bus.done, sub_bus.busy}, 0);
        end
        start_op(4'd8, 4'd1, 1'b0);
        wait_done(cyc);
        chk("t4_D2",  sub_bus.D, 4'd7);
        chk("t4_Bo2", sub_bus.Bo, 0);
        step();

        // 5: back-to-back start in the DONE cycle
        start_op(4'd4, 4'd4, 1'b0);
        wait_done(cyc);
        chk("t5_D0",  sub_bus.D, 4'd0);
        chk("t5_Bo0", sub_bus.Bo, 0);
        start_op(4'd2, 4'd1, 1'b0);
        chk("t5_drop",  sub_bus.done, 0);
        chk("t5_busy",  sub_bus.busy, 1);
        chk("t5_Dheld", sub_bus.D, 4'd0);
        wait_done(cyc);
        chk("t5_lat", cyc, 4);
        chk("t5_D1",  sub_bus.D, 4'd1);
        chk("t5_Bo1", sub_bus.Bo, 0);
        step();

`ifdef SERIAL_SUB_OVF_EN
        // 6: signed overflow flag
        start_op(4'd7, 4'hF, 1'b0);
        wait_done(cyc);
        chk("t6a_D",  sub_bus.D, 4'h8);
        chk("t6a_Bo", sub_bus.Bo, 1);
        chk("t6a_V",  sub_bus.V, 1);
        step();
        start_op(4'd6, 4'd2, 1'b0);
        wait_done(cyc);
        chk("t6b_D", sub_bus.D, 4'd4);
        chk("t6b_V", sub_bus.V, 0);
        step();
`endif

        // exhaustive sweep against A - B - Bi
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    run_check(4'(a), 4'(b), 1'(bi));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
